// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM controller.
//   state_e   : controller FSM states
//   HalfLo/Hi : SRAM address LSB selecting the low/high 16-bit half of a word
//   cnt_width : width of the per-half access down-counter
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } state_e;

    localparam logic HalfLo = 1'b0;
    localparam logic HalfHi = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned access_cycles);
        return $clog2(access_cycles + 1);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle of the SRAM controller.
//   wr_en, rd_en : request strobes from the MEM stage (write wins when both high)
//   address      : byte address, word aligned
//   write_data   : store data
//   read_data    : registered load data
//   ready        : low while a request is being serviced
//   error        : out-of-range flag (only with SRAM_CTRL_RANGE_CHECK_EN)
interface sram_controller_if #(
    parameter int unsigned BIT_NUMBER = 32
) ();

    logic                  wr_en;
    logic                  rd_en;
    logic [BIT_NUMBER-1:0] address;
    logic [BIT_NUMBER-1:0] write_data;
    logic [BIT_NUMBER-1:0] read_data;
    logic                  ready;
    logic                  error;

    modport master (
        output wr_en,
        output rd_en,
        output address,
        output write_data,
        input  read_data,
        input  ready,
        input  error
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  address,
        input  write_data,
        output read_data,
        output ready,
        output error
    );

endinterface

// File: rtl/Register.sv
// Pipeline-style register with freeze.
//   clk, rst : clock, asynchronous active-low reset (clears to zero)
//   freeze   : hold the current value when high
//   d, q     : data in / registered data out
module Register #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (!freeze) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: each 32-bit request becomes two 16-bit accesses
// (low half, then high half) on an external asynchronous SRAM.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : pipeline request/response (sram_controller_if.slave)
//   sram_dq     : bidirectional SRAM data bus
//   sram_addr   : SRAM half-word address {word index, half select}
//   sram_we_n   : active-low write enable
//   sram_oe_n   : active-low output enable
// Optional feature: define SRAM_CTRL_RANGE_CHECK_EN to reject addresses below BASE_ADDR
// or past the end of the SRAM; rejected requests finish in one DONE cycle with error=1.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BIT_NUMBER      = 32,
    parameter int unsigned SRAM_DATA_WIDTH = 16,
    parameter int unsigned SRAM_ADDR_WIDTH = 18,
    parameter int unsigned BASE_ADDR       = 1024,
    parameter int unsigned ACCESS_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_controller_if.slave           bus,
    inout  wire  [SRAM_DATA_WIDTH-1:0] sram_dq,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic                       sram_we_n,
    output logic                       sram_oe_n
);

    localparam int unsigned CntW = cnt_width(ACCESS_CYCLES);
    localparam int unsigned IdxW = SRAM_ADDR_WIDTH - 1;
    localparam int unsigned ReqW = 1 + 2 * BIT_NUMBER;
    localparam logic [CntW-1:0] CntLoad = CntW'(ACCESS_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0] lo_half_q, lo_half_d;
    logic [BIT_NUMBER-1:0]      read_data_q, read_data_d;
    logic                       err_q, err_d;

    logic                       req;
    logic [ReqW-1:0]            req_d, req_q;
    logic                       req_write;
    logic [BIT_NUMBER-1:0]      req_addr;
    logic [BIT_NUMBER-1:0]      req_wdata;
    logic [BIT_NUMBER-1:0]      live_off, lat_off;
    logic [IdxW-1:0]            live_idx, lat_idx;
    logic                       out_of_range;
    logic                       dq_oe;
    logic [SRAM_DATA_WIDTH-1:0] dq_out;
    logic                       unused_off_bits;

    assign req = bus.rd_en | bus.wr_en;

    // Latched request; keeps loading while idle so it holds the accepted request afterwards.
    assign req_d = {bus.wr_en, bus.address, bus.write_data};

    Register #(
        .Width (ReqW)
    ) u_req_reg (
        .clk    (clk),
        .rst    (rst),
        .freeze (state_q != StIdle),
        .d      (req_d),
        .q      (req_q)
    );

    assign req_write = req_q[ReqW-1];
    assign req_addr  = req_q[2*BIT_NUMBER-1:BIT_NUMBER];
    assign req_wdata = req_q[BIT_NUMBER-1:0];

    // Word index; truncation to IdxW bits wraps modulo the SRAM size.
    assign live_off = bus.address - BIT_NUMBER'(BASE_ADDR);
    assign lat_off  = req_addr - BIT_NUMBER'(BASE_ADDR);
    assign live_idx = live_off[IdxW+1:2];
    assign lat_idx  = lat_off[IdxW+1:2];

    assign unused_off_bits = ^{live_off[1:0], live_off[BIT_NUMBER-1:IdxW+2],
                               lat_off[1:0], lat_off[BIT_NUMBER-1:IdxW+2]};

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    assign out_of_range = (bus.address < BIT_NUMBER'(BASE_ADDR)) ||
                          (|live_off[BIT_NUMBER-1:IdxW+2]);
`else
    // Without the check err_q can never be set, so error stays 0.
    assign out_of_range = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            lo_half_q   <= '0;
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            lo_half_q   <= lo_half_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        lo_half_d   = lo_half_q;
        read_data_d = read_data_q;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (out_of_range) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        if (!bus.wr_en) begin
                            read_data_d = '0;
                        end
                    end else begin
                        state_d = StLo;
                        cnt_d   = CntLoad;
                        addr_d  = {live_idx, HalfLo};
                    end
                end
            end
            StLo: begin
                if (cnt_q == '0) begin
                    state_d = StHi;
                    cnt_d   = CntLoad;
                    addr_d  = {lat_idx, HalfHi};
                    if (!req_write) begin
                        lo_half_d = sram_dq;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHi: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    // Whole word lands at once on entry to DONE.
                    if (!req_write) begin
                        read_data_d = BIT_NUMBER'({sram_dq, lo_half_q});
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = req_wdata[SRAM_DATA_WIDTH-1:0];
        unique case (state_q)
            StLo: begin
                if (req_write) begin
                    sram_we_n = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = req_wdata[SRAM_DATA_WIDTH-1:0];
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            StHi: begin
                if (req_write) begin
                    sram_we_n = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = req_wdata[2*SRAM_DATA_WIDTH-1:SRAM_DATA_WIDTH];
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign sram_dq       = dq_oe ? dq_out : {SRAM_DATA_WIDTH{1'bz}};
    assign sram_addr     = addr_q;
    assign bus.read_data = read_data_q;
    assign bus.error     = err_q;
    assign bus.ready     = ~req | (state_q == StDone);

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed transfers against an SRAM device
// model, with a per-cycle timeline model of the expected pipeline and SRAM pins.
module tb_sram_controller;

    localparam int AC  = 2;
    localparam int LEN = 1 + 2 * AC;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if #(.BIT_NUMBER(32)) bus ();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_controller #(
        .BIT_NUMBER      (32),
        .SRAM_DATA_WIDTH (16),
        .SRAM_ADDR_WIDTH (18),
        .BASE_ADDR       (1024),
        .ACCESS_CYCLES   (AC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_dq   (sram_dq),
        .sram_addr (sram_addr),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n)
    );

    // Undriven bus floats high, so a released bus reads 16'hFFFF.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_dq[g]);
    end

    // External SRAM device
    logic [15:0] dev_mem [0:262143];
    logic        dev_drive;
    assign dev_drive = !sram_oe_n && sram_we_n;
    assign sram_dq   = dev_drive ? dev_mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) dev_mem[sram_addr] <= sram_dq;
    end

    // Reference model state
    logic [15:0] ref_mem [int];
    int          cyc = -1;
    int          cur_len = LEN;
    logic        cur_wr = 1'b0;
    logic        cur_oor = 1'b0;
    logic [16:0] cur_word = '0;
    logic [31:0] cur_data = '0;
    logic [31:0] cur_rdval = '0;
    logic [31:0] exp_rd = '0;
    bit          skip = 1'b1;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_rd(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
    endfunction

    // Per-cycle compare against the transfer timeline
    always @(negedge clk) begin : cmp
        logic in_lo;
        logic in_hi;
        logic active;
        if (!skip) begin
            active = (cyc >= 0);
            if (active && cyc == cur_len && !cur_wr) exp_rd = cur_rdval;
            in_lo = active && !cur_oor && cyc >= 1 && cyc <= AC;
            in_hi = active && !cur_oor && cyc > AC && cyc <= 2 * AC;
            chk("ready", 32'(bus.ready), 32'(!active || cyc == cur_len));
            chk("read_data", bus.read_data, exp_rd);
            chk("error", 32'(bus.error), 32'(active && cur_oor && cyc == cur_len));
            if (in_lo || in_hi) begin
                chk("sram_addr", 32'(sram_addr), 32'({cur_word, in_hi}));
                chk("sram_we_n", 32'(sram_we_n), 32'(!cur_wr));
                chk("sram_oe_n", 32'(sram_oe_n), 32'(cur_wr));
                if (cur_wr) chk("sram_dq", 32'(sram_dq),
                                in_hi ? 32'(cur_data[31:16]) : 32'(cur_data[15:0]));
            end else begin
                chk("idle_we_n", 32'(sram_we_n), 32'd1);
                chk("idle_oe_n", 32'(sram_oe_n), 32'd1);
                chk("idle_dq", 32'(sram_dq), 32'h0000_FFFF);
            end
        end
    end

    task automatic setup_req(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        bus.wr_en      = w;
        bus.rd_en      = r;
        bus.address    = a;
        bus.write_data = d;
        cur_wr   = w;
        cur_data = d;
        cur_word = off[18:2];
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        cur_oor = (a < BASE) || (off[31:19] != 13'd0);
`else
        cur_oor = 1'b0;
`endif
        cur_len = cur_oor ? 1 : LEN;
        if (cur_oor) begin
            cur_rdval = 32'h0;
        end else if (w) begin
            ref_mem[2 * int'(cur_word)]     = d[15:0];
            ref_mem[2 * int'(cur_word) + 1] = d[31:16];
        end else begin
            cur_rdval = {ref_rd(2 * int'(cur_word) + 1), ref_rd(2 * int'(cur_word))};
        end
    endtask

    // Called just after a rising edge with the FSM idle.
    task automatic xfer(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d);
        setup_req(w, r, a, d);
        for (int c = 0; c <= cur_len; c++) begin
            cyc = c;
            @(posedge clk);
            #1;
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        cyc = -1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        chk({tag, "_read_data"}, bus.read_data, 32'h0);
        chk({tag, "_error"}, 32'(bus.error), 32'd0);
        chk({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_dq"}, 32'(sram_dq), 32'h0000_FFFF);
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;

        repeat (2) @(negedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        #2 rst = 1'b1;
        skip = 1'b0;
        @(posedge clk);
        #1;

        xfer(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        chk("mem0_after_w1", 32'(dev_mem[0]), 32'h0000_BEEF);
        chk("mem1_after_w1", 32'(dev_mem[1]), 32'h0000_DEAD);

        xfer(1'b0, 1'b1, 32'd1024, 32'h0);
        chk("rd1024", bus.read_data, 32'hDEADBEEF);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rd1024_held", bus.read_data, 32'hDEADBEEF);

        xfer(1'b1, 1'b0, 32'd1032, 32'h12345678);
        chk("mem4", 32'(dev_mem[4]), 32'h0000_5678);
        chk("mem5", 32'(dev_mem[5]), 32'h0000_1234);
        chk("mem0_kept", 32'(dev_mem[0]), 32'h0000_BEEF);
        chk("mem1_kept", 32'(dev_mem[1]), 32'h0000_DEAD);

        // Both strobes high: the write wins
        xfer(1'b1, 1'b1, 32'd1036, 32'hCAFEF00D);
        chk("mem6", 32'(dev_mem[6]), 32'h0000_F00D);
        chk("mem7", 32'(dev_mem[7]), 32'h0000_CAFE);
        chk("rd_after_both", bus.read_data, 32'hDEADBEEF);

        // Back-to-back reads
        xfer(1'b0, 1'b1, 32'd1032, 32'h0);
        xfer(1'b0, 1'b1, 32'd1036, 32'h0);
        chk("rd1036", bus.read_data, 32'hCAFEF00D);

        // Reset during the HI half of a write
        setup_req(1'b1, 1'b0, 32'd1040, 32'hAAAA5555);
        for (int c = 0; c <= AC; c++) begin
            cyc = c;
            @(posedge clk);
            #1;
        end
        cyc = AC + 1;
        @(negedge clk);
        #2;
        skip = 1'b1;
        rst = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        reset_checks("midreset");
        exp_rd = 32'h0;
        cyc = -1;
        @(posedge clk);
        #3 rst = 1'b1;
        skip = 1'b0;
        @(posedge clk);
        #1;

        xfer(1'b0, 1'b1, 32'd1024, 32'h0);
        chk("rd_after_reset", bus.read_data, 32'hDEADBEEF);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        xfer(1'b0, 1'b1, 32'd512, 32'h0);
        chk("oor_low_rd", bus.read_data, 32'h0);
        xfer(1'b0, 1'b1, 32'd1024 + 32'd4 * 32'd131072, 32'h0);
        chk("oor_high_rd", bus.read_data, 32'h0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
